// File: rtl/naneye_rx_decoder_if.sv
// Signal bundle between the NanEye Manchester decoder and its neighbours
// (sensor pad, configuration module and deserializer).
interface naneye_rx_decoder_if;
    logic        ENABLE;
    logic        RSYNC;
    logic        INPUT;
    logic        CONFIG_DONE;
    logic        CONFIG_EN;
    logic        SYNC_START;
    logic        FRAME_START;
    logic        OUTPUT;
    logic        OUTPUT_EN;
    logic        NANEYE3A_NANEYE2B_N;
    logic        ERROR_OUT;
    logic [31:0] DEBUG_OUT;

    // Decoder side.
    modport master (
        input  ENABLE,
        input  RSYNC,
        input  INPUT,
        input  CONFIG_DONE,
        output CONFIG_EN,
        output SYNC_START,
        output FRAME_START,
        output OUTPUT,
        output OUTPUT_EN,
        output NANEYE3A_NANEYE2B_N,
        output ERROR_OUT,
        output DEBUG_OUT
    );

    // Pad / deserializer / configuration side.
    modport slave (
        output ENABLE,
        output RSYNC,
        output INPUT,
        output CONFIG_DONE,
        input  CONFIG_EN,
        input  SYNC_START,
        input  FRAME_START,
        input  OUTPUT,
        input  OUTPUT_EN,
        input  NANEYE3A_NANEYE2B_N,
        input  ERROR_OUT,
        input  DEBUG_OUT
    );
endinterface

// File: rtl/naneye_rx_decoder.sv
// NanEye Manchester line decoder: run-length classification, sync detection and bit recovery.
// Optional status counters on DEBUG_OUT when RX_DECODER_DEBUG_EN is defined.
module naneye_rx_decoder #(
    parameter int unsigned SHORT_MAX = 3,
    parameter int unsigned LONG_MAX  = 7,
    parameter int unsigned SYNC_MIN  = 64,
    parameter int unsigned SYNC_3A   = 1024
) (
    input logic                 CLOCK,
    input logic                 RESET,
    naneye_rx_decoder_if.master bus
);

    localparam logic [11:0] ShortMax = 12'(SHORT_MAX);
    localparam logic [11:0] LongMax  = 12'(LONG_MAX);
    localparam logic [11:0] SyncMin  = 12'(SYNC_MIN);
    localparam logic [11:0] Sync3a   = 12'(SYNC_3A);

    typedef enum logic [1:0] {
        StHunt,
        StSync,
        StData
    } state_e;

    state_e      state_q, state_d;
    logic        in_meta_q, in_sync_q, in_prev_q;
    logic        line_edge;
    logic [11:0] run_q, run_d;
    logic        phase_q, phase_d;
    logic        config_en_q, config_en_d;
    logic        sync_start_q, sync_start_d;
    logic        frame_start_q, frame_start_d;
    logic        out_q, out_d;
    logic        out_en_q, out_en_d;
    logic        type_q, type_d;
    logic        err_q, err_d;
    logic        run_short, run_long, sync_hit, sync_is_3a;

    // Two-stage synchroniser plus one history stage for edge detection.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            in_meta_q <= 1'b0;
            in_sync_q <= 1'b0;
            in_prev_q <= 1'b0;
        end else begin
            in_meta_q <= bus.INPUT;
            in_sync_q <= in_meta_q;
            in_prev_q <= in_sync_q;
        end
    end

    assign line_edge = in_sync_q ^ in_prev_q;

    // Run counter keeps counting regardless of state so sync survives ENABLE/RSYNC.
    always_comb begin
        run_d = run_q;
        if (line_edge) begin
            run_d = 12'd1;
        end else if (run_q != 12'hfff) begin
            run_d = run_q + 12'd1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            run_q <= 12'd0;
        end else begin
            run_q <= run_d;
        end
    end

    assign run_short  = (run_q != 12'd0) && (run_q <= ShortMax);
    assign run_long   = (run_q > ShortMax) && (run_q <= LongMax);
    assign sync_hit   = (run_q >= SyncMin);
    assign sync_is_3a = (run_q >= Sync3a);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StHunt;
            phase_q       <= 1'b0;
            config_en_q   <= 1'b0;
            sync_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            out_q         <= 1'b0;
            out_en_q      <= 1'b0;
            type_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            config_en_q   <= config_en_d;
            sync_start_q  <= sync_start_d;
            frame_start_q <= frame_start_d;
            out_q         <= out_d;
            out_en_q      <= out_en_d;
            type_q        <= type_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        config_en_d   = config_en_q;
        sync_start_d  = 1'b0;
        frame_start_d = 1'b0;
        out_d         = out_q;
        out_en_d      = 1'b0;
        type_d        = type_q;
        err_d         = 1'b0;

        if (!bus.ENABLE || bus.RSYNC) begin
            state_d     = StHunt;
            phase_d     = 1'b0;
            config_en_d = 1'b0;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (sync_hit) begin
                        state_d      = StSync;
                        sync_start_d = 1'b1;
                        config_en_d  = 1'b1;
                    end
                end
                StSync: begin
                    if (line_edge) begin
                        // Edge ending sync is the mid-bit of bit 0.
                        state_d       = StData;
                        frame_start_d = 1'b1;
                        type_d        = sync_is_3a;
                        out_d         = in_sync_q;
                        out_en_d      = 1'b1;
                        phase_d       = 1'b1;
                        config_en_d   = 1'b0;
                    end else if (bus.CONFIG_DONE) begin
                        config_en_d = 1'b0;
                    end
                end
                StData: begin
                    if (sync_hit) begin
                        state_d      = StSync;
                        sync_start_d = 1'b1;
                        config_en_d  = 1'b1;
                        phase_d      = 1'b0;
                    end else if (line_edge) begin
                        if (run_short) begin
                            if (phase_q) begin
                                phase_d = 1'b0;
                            end else begin
                                out_d    = in_sync_q;
                                out_en_d = 1'b1;
                                phase_d  = 1'b1;
                            end
                        end else if (run_long && phase_q) begin
                            out_d    = in_sync_q;
                            out_en_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StHunt;
                            phase_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.CONFIG_EN           = config_en_q;
    assign bus.SYNC_START          = sync_start_q;
    assign bus.FRAME_START         = frame_start_q;
    assign bus.OUTPUT              = out_q;
    assign bus.OUTPUT_EN           = out_en_q;
    assign bus.NANEYE3A_NANEYE2B_N = type_q;
    assign bus.ERROR_OUT           = err_q;

`ifdef RX_DECODER_DEBUG_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  last_run_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 8'd0;
            last_run_q  <= 8'd0;
        end else begin
            if (frame_start_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (err_d && (err_cnt_q != 8'hff)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            if (line_edge) begin
                last_run_q <= (run_q > 12'd255) ? 8'hff : run_q[7:0];
            end
        end
    end

    assign bus.DEBUG_OUT = {last_run_q, err_cnt_q, frame_cnt_q};
`else
    assign bus.DEBUG_OUT = 32'd0;
`endif

endmodule

// File: tb/tb_naneye_rx_decoder.sv
// Directed self-checking bench for naneye_rx_decoder: sync, decoding, sensor type,
// line errors, RSYNC, ENABLE gating and the optional debug counters.
module tb_naneye_rx_decoder;

    logic CLOCK_tb = 1'b0;
    logic RESET_tb;

    always #5 CLOCK_tb = ~CLOCK_tb;

    naneye_rx_decoder_if bus ();

    naneye_rx_decoder #(
        .SHORT_MAX(3),
        .LONG_MAX (7),
        .SYNC_MIN (64),
        .SYNC_3A  (1024)
    ) dut (
        .CLOCK(CLOCK_tb),
        .RESET(RESET_tb),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_sync = 0, cnt_frame = 0, cnt_oen = 0, cnt_err = 0, cnt_multi = 0;
    logic bits_q[$];
    logic prev_ss = 1'b0, prev_fs = 1'b0, prev_oe = 1'b0, prev_er = 1'b0;

    // Pulse counting and bit capture, sampled on the falling edge.
    always @(negedge CLOCK_tb) begin
        if (!RESET_tb) begin
            if (bus.SYNC_START)  cnt_sync++;
            if (bus.FRAME_START) cnt_frame++;
            if (bus.ERROR_OUT)   cnt_err++;
            if (bus.OUTPUT_EN) begin
                cnt_oen++;
                bits_q.push_back(bus.OUTPUT);
            end
            if ((bus.SYNC_START && prev_ss) || (bus.FRAME_START && prev_fs) ||
                (bus.OUTPUT_EN && prev_oe) || (bus.ERROR_OUT && prev_er)) begin
                cnt_multi++;
            end
            prev_ss = bus.SYNC_START;
            prev_fs = bus.FRAME_START;
            prev_oe = bus.OUTPUT_EN;
            prev_er = bus.ERROR_OUT;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.INPUT = v;
        repeat (n) @(negedge CLOCK_tb);
    endtask

    task automatic check_bit(input string tag, input int idx, input logic exp);
        logic b;
        b = (idx < bits_q.size()) ? bits_q[idx] : 1'bx;
        check_eq(tag, {31'd0, b}, {31'd0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int s_sync, s_frame, s_oen, s_err, s_bit, lat;
    logic [4:0] exp_b;

    initial begin
        bus.ENABLE      = 1'b1;
        bus.RSYNC       = 1'b0;
        bus.INPUT       = 1'b0;
        bus.CONFIG_DONE = 1'b0;
        RESET_tb        = 1'b1;
        repeat (3) @(negedge CLOCK_tb);

        check_eq("rst_config_en",   {31'd0, bus.CONFIG_EN}, 0);
        check_eq("rst_sync_start",  {31'd0, bus.SYNC_START}, 0);
        check_eq("rst_frame_start", {31'd0, bus.FRAME_START}, 0);
        check_eq("rst_output_en",   {31'd0, bus.OUTPUT_EN}, 0);
        check_eq("rst_output",      {31'd0, bus.OUTPUT}, 0);
        check_eq("rst_type",        {31'd0, bus.NANEYE3A_NANEYE2B_N}, 0);
        check_eq("rst_error",       {31'd0, bus.ERROR_OUT}, 0);
        check_eq("rst_debug",       bus.DEBUG_OUT, 0);

        // First sync straight out of reset with the line held low.
        RESET_tb = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CLOCK_tb);
            if (bus.SYNC_START) begin
                lat = i;
                break;
            end
        end
        check_eq("sync_seen", {31'd0, lat != 0}, 1);
        check_eq("sync_latency_window", {31'd0, (lat >= 64) && (lat <= 68)}, 1);
        check_eq("config_en_open", {31'd0, bus.CONFIG_EN}, 1);
        @(negedge CLOCK_tb);
        check_eq("sync_start_width", {31'd0, bus.SYNC_START}, 0);
        check_eq("config_en_held", {31'd0, bus.CONFIG_EN}, 1);
        bus.CONFIG_DONE = 1'b1;
        @(negedge CLOCK_tb);
        bus.CONFIG_DONE = 1'b0;
        check_eq("config_en_closed", {31'd0, bus.CONFIG_EN}, 0);

        // Frame of bits 1 (bit 0), 1, 0, 1, 1 with jittered half-bits.
        s_frame = cnt_frame; s_oen = cnt_oen; s_err = cnt_err; s_bit = bits_q.size();
        hold(0, 200);
        hold(1, 2); hold(0, 3); hold(1, 5); hold(0, 4); hold(1, 2); hold(0, 3); hold(1, 10);
        check_eq("b_frame_cnt", cnt_frame - s_frame, 1);
        check_eq("b_oen_cnt", cnt_oen - s_oen, 5);
        check_eq("b_err_cnt", cnt_err - s_err, 0);
        exp_b = 5'b11011;
        for (int i = 0; i < 5; i++) check_bit("b_bit", s_bit + i, exp_b[4 - i]);
        check_eq("b_type_2b", {31'd0, bus.NANEYE3A_NANEYE2B_N}, 0);
        check_eq("b_config_en", {31'd0, bus.CONFIG_EN}, 0);

        // Long high sync (NanEye3A), two bits, then a 20-sample run error.
        s_sync = cnt_sync; s_frame = cnt_frame; s_oen = cnt_oen; s_err = cnt_err;
        s_bit = bits_q.size();
        hold(1, 1090);
        hold(0, 2); hold(1, 3); hold(0, 20); hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 5);
        check_eq("c_sync_cnt", cnt_sync - s_sync, 1);
        check_eq("c_frame_cnt", cnt_frame - s_frame, 1);
        check_eq("c_type_3a", {31'd0, bus.NANEYE3A_NANEYE2B_N}, 1);
        check_eq("c_err_cnt", cnt_err - s_err, 1);
        check_eq("c_oen_cnt", cnt_oen - s_oen, 2);
        check_bit("c_bit0", s_bit, 1'b0);
        check_bit("c_bit1", s_bit + 1, 1'b0);

        // Resume after error, then RSYNC mid-frame.
        s_sync = cnt_sync; s_frame = cnt_frame; s_oen = cnt_oen; s_err = cnt_err;
        s_bit = bits_q.size();
        hold(0, 95);
        hold(1, 2); hold(0, 2);
        bus.INPUT = 1'b1;
        repeat (5) @(negedge CLOCK_tb);
        check_eq("d_sync_cnt", cnt_sync - s_sync, 1);
        check_eq("d_frame_cnt", cnt_frame - s_frame, 1);
        check_eq("d_oen_cnt", cnt_oen - s_oen, 2);
        check_bit("d_bit0", s_bit, 1'b1);
        check_bit("d_bit1", s_bit + 1, 1'b1);
        s_oen = cnt_oen;
        bus.RSYNC = 1'b1;
        @(negedge CLOCK_tb);
        bus.RSYNC = 1'b0;
        for (int k = 0; k < 5; k++) begin
            hold(0, 2);
            hold(1, 2);
        end
        hold(1, 5);
        check_eq("d_oen_after_rsync", cnt_oen - s_oen, 0);
        check_eq("d_err_after_rsync", cnt_err - s_err, 0);

        // Fresh 100-sample low sync re-arms decoding; type returns to 2B.
        s_sync = cnt_sync; s_frame = cnt_frame; s_oen = cnt_oen; s_bit = bits_q.size();
        hold(0, 100);
        hold(1, 8);
        check_eq("e_sync_cnt", cnt_sync - s_sync, 1);
        check_eq("e_frame_cnt", cnt_frame - s_frame, 1);
        check_eq("e_oen_cnt", cnt_oen - s_oen, 1);
        check_bit("e_bit0", s_bit, 1'b1);
        check_eq("e_type_2b", {31'd0, bus.NANEYE3A_NANEYE2B_N}, 0);

        // Sync while disabled: no SYNC_START until release, then immediate.
        s_sync = cnt_sync; s_oen = cnt_oen; s_err = cnt_err;
        bus.ENABLE = 1'b0;
        hold(0, 80);
        check_eq("f_sync_while_disabled", cnt_sync - s_sync, 0);
        check_eq("f_oen_while_disabled", cnt_oen - s_oen, 0);
        check_eq("f_err_while_disabled", cnt_err - s_err, 0);
        check_eq("f_config_en_disabled", {31'd0, bus.CONFIG_EN}, 0);
        bus.ENABLE = 1'b1;
        repeat (4) @(negedge CLOCK_tb);
        check_eq("f_sync_on_release", cnt_sync - s_sync, 1);
        check_eq("f_config_en_release", {31'd0, bus.CONFIG_EN}, 1);

        check_eq("total_sync_cnt", cnt_sync, 5);
        check_eq("total_frame_cnt", cnt_frame, 4);
        check_eq("total_err_cnt", cnt_err, 1);
`ifdef RX_DECODER_DEBUG_EN
        check_eq("debug_frames", {16'd0, bus.DEBUG_OUT[15:0]}, 4);
        check_eq("debug_errors", {24'd0, bus.DEBUG_OUT[23:16]}, 1);
`else
        check_eq("debug_zero", bus.DEBUG_OUT, 0);
`endif
        check_eq("pulse_width_violations", cnt_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
